fp_s_wb: RTL and testbench
==========================

FP_S_WB -- requirements
Module: fp_s_wb

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered results (power of two, 2..8).
REQ-002 SHALL have parameter RD_W, default 5, destination register index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream single-precision result valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept a result this cycle.
REQ-007 SHALL have port in_rd  input  RD_W  destination FP register index.
REQ-008 SHALL have port in_s  input  32  single-precision result from the double-to-single converter.
REQ-009 SHALL have port in_flags  input  5  exception flags {NV,DZ,OF,UF,NX} for in_s.
REQ-010 SHALL have port out_valid  output  1  register-file write request valid.
REQ-011 SHALL have port out_ready  input  1  register file accepts the write.
REQ-012 SHALL have port out_rd  output  RD_W  write index.
REQ-013 SHALL have port out_data  output  64  NaN-boxed write data.
REQ-014 SHALL have port fflags_clr  input  1  synchronous clear of accrued flags.
REQ-015 SHALL have port fflags  output  5  accrued (sticky) exception flags.
REQ-016 SHALL have port busy  output  1  high while any entry is buffered.

Function
REQ-017 SHALL implement a DEPTH-entry FIFO of {rd, s, flags}; push = in_valid & in_ready, pop = out_valid & out_ready.
REQ-018 SHALL drive in_ready = (count < DEPTH), independent of out_ready and in_valid (no combinational path in to out).
REQ-019 SHALL present out_valid = (count != 0); no same-cycle bypass: a result pushed in cycle N is first visible in cycle N+1.
REQ-020 SHALL drive out_data = {32'hFFFF_FFFF, head.s} and out_rd = head.rd, both stable while out_valid & !out_ready.
REQ-021 SHALL pass in_s bit-exact (no NaN re-canonicalisation; converter already emits 0x7FC00000).
REQ-022 SHALL support simultaneous push and pop when 0 < count < DEPTH, count unchanged.
REQ-023 SHALL ignore in_valid when full (in_ready low); data on in_* is not captured.
REQ-024 SHALL use read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH, count of log2(DEPTH)+1 bits.
REQ-025 SHALL update fflags on pop: fflags_next = (fflags_clr ? 0 : fflags) | (pop ? head.flags : 0) (clear applied before OR).
REQ-026 SHALL drive busy = out_valid.

Reset
REQ-027 SHALL on rst asynchronously clear pointers, count and fflags: out_valid=0, in_ready=1, fflags=0, busy=0, out_rd=0, out_data=64'hFFFF_FFFF_0000_0000.
REQ-028 SHALL discard all buffered entries on reset mid-operation; no write issued for them after release.

Configuration
REQ-029 SHALL honour macro FP_WB_FFLAGS_EN: defined -> flag storage, accumulation and fflags_clr per REQ-025.
REQ-030 SHALL, without FP_WB_FFLAGS_EN, omit flag storage from FIFO entries, ignore in_flags and fflags_clr, and tie fflags to 0.

Structure
REQ-031 SHALL place in shared package fp_pkg: flag bit positions (NV=4..NX=0), NaN-box constant 32'hFFFF_FFFF, canonical single NaN 32'h7FC0_0000, and the entry typedef.
REQ-032 SHALL contain one sub-module fp_wb_fifo (generic DEPTH x width storage with pointers and count); boxing and flag logic stay in fp_s_wb.

Verification
REQ-033 SHALL verify single push in_s=32'h3F80_0000, rd=3, out_ready=1 -> next cycle out_valid=1, out_data=64'hFFFF_FFFF_3F80_0000, out_rd=3; empty after pop.
REQ-034 SHALL verify back-pressure: out_ready=0, push 0x4000_0000 then 0x4040_0000 -> in_ready=0 after 2nd push, 3rd in_valid ignored; release -> order 0x4000_0000, 0x4040_0000.
REQ-035 SHALL verify flags: pop entries with flags 5'b00001 then 5'b00100 -> fflags=5'b00101; fflags_clr in same cycle as pop of 5'b10000 -> fflags=5'b10000.
REQ-036 SHALL verify wrap-around: 10 continuous pushes with out_ready toggling 1/0 -> all 10 written in order, no loss or duplicate.
REQ-037 SHALL verify rst asserted with 2 entries buffered -> out_valid=0, fflags=0 immediately (asynchronously); first push after release appears as the next write.
REQ-038 SHALL verify build without FP_WB_FFLAGS_EN: in_flags=5'b11111 on every push -> fflags stays 0, data path unchanged.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point constants and bundle types.
// Used by the single-precision writeback stage.
package fp_pkg;

  localparam int FL_NV = 4;
  localparam int FL_DZ = 3;
  localparam int FL_OF = 2;
  localparam int FL_UF = 1;
  localparam int FL_NX = 0;

  localparam logic [31:0] NAN_BOX = 32'hFFFF_FFFF;
  localparam logic [31:0] S_QNAN  = 32'h7FC0_0000;

  typedef struct packed {
    logic [31:0] s;
    logic [4:0]  flags;
  } s_res_t;

  localparam int S_RES_W = $bits(s_res_t);

endpackage

// File: rtl/fp_wb_fifo.sv
// Generic DEPTH x W result buffer.
// Power-of-two depth; pointers wrap naturally.
module fp_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rp];

endmodule

// File: rtl/fp_s_wb.sv
// Single-precision writeback: buffers converted results, NaN-boxes them.
// FP_WB_FFLAGS_EN enables sticky exception flag accumulation.
module fp_s_wb
  import fp_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int RD_W  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RD_W-1:0] in_rd,
  input  logic [31:0]     in_s,
  input  logic [4:0]      in_flags,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RD_W-1:0] out_rd,
  output logic [63:0]     out_data,
  input  logic            fflags_clr,
  output logic [4:0]      fflags,
  output logic            busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

`ifdef FP_WB_FFLAGS_EN
  localparam int EW = RD_W + S_RES_W;
`else
  localparam int EW = RD_W + 32;
`endif

  logic [EW-1:0]   wdata;
  logic [EW-1:0]   rdata;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic [RD_W-1:0] head_rd;
  logic [31:0]     head_s;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign busy      = out_valid;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  fp_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (count)
  );

`ifdef FP_WB_FFLAGS_EN
  s_res_t w_res;
  s_res_t h_res;

  // pack/unpack entries carrying flags
  always_comb begin
    w_res.s     = in_s;
    w_res.flags = in_flags;
    wdata       = {in_rd, w_res};
    {head_rd, h_res} = rdata;
    head_s      = h_res.s;
  end

  // sticky flags: clear first, then OR in popped entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fflags <= '0;
    end else begin
      fflags <= (fflags_clr ? 5'b0 : fflags)
              | (pop ? h_res.flags : 5'b0);
    end
  end
`else
  logic unused_flag_in;

  // pack/unpack entries without flags
  always_comb begin
    wdata = {in_rd, in_s};
    {head_rd, head_s} = rdata;
  end

  assign unused_flag_in = ^{in_flags, fflags_clr};
  assign fflags         = '0;
`endif

  assign out_rd   = out_valid ? head_rd : '0;
  assign out_data = {NAN_BOX, out_valid ? head_s : 32'h0};

endmodule

// File: tb/tb_fp_s_wb.sv
// Directed bench for fp_s_wb with a queue-based reference model.
// Honours FP_WB_FFLAGS_EN for expected flag values.
module tb_fp_s_wb;

  localparam int DEPTH = 2;
  localparam int RD_W  = 5;
`ifdef FP_WB_FFLAGS_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [RD_W-1:0] in_rd = '0;
  logic [31:0]     in_s = '0;
  logic [4:0]      in_flags = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [RD_W-1:0] out_rd;
  logic [63:0]     out_data;
  logic            fflags_clr = 1'b0;
  logic [4:0]      fflags;
  logic            busy;

  fp_s_wb #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_s       (in_s),
    .in_flags   (in_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rd     (out_rd),
    .out_data   (out_data),
    .fflags_clr (fflags_clr),
    .fflags     (fflags),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     s;
    logic [RD_W-1:0] rd;
    logic [4:0]      f;
  } ent_t;

  ent_t        mq[$];
  logic [4:0]  mf = '0;
  logic [31:0] dut_log[$];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // one clock: reference model advances on the edge
  task automatic step();
    bit pu;
    bit po;
    logic [4:0] hf;
    ent_t e;
    @(posedge clk);
    if (!rst) begin
      pu = in_valid && (mq.size() < DEPTH);
      po = out_ready && (mq.size() != 0);
      hf = po ? mq[0].f : 5'b0;
      if (po) void'(mq.pop_front());
      if (pu) begin
        e.s = in_s; e.rd = in_rd; e.f = in_flags;
        mq.push_back(e);
      end
      mf = EN ? ((fflags_clr ? 5'b0 : mf) | hf) : 5'b0;
    end
    #1;
  endtask

  task automatic push1(input logic [31:0] s,
                       input logic [RD_W-1:0] rd,
                       input logic [4:0] f);
    in_valid = 1'b1; in_s = s; in_rd = rd; in_flags = f;
    step();
    in_valid = 1'b0;
  endtask

  // per-cycle compare against the model; also records writes
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
      check("busy", 64'(busy), 64'(mq.size() != 0));
      check("fflags", 64'(fflags), 64'(mf));
      if (mq.size() != 0) begin
        check("out_data", out_data, {32'hFFFF_FFFF, mq[0].s});
        check("out_rd", 64'(out_rd), 64'(mq[0].rd));
      end
      if (out_valid && out_ready) dut_log.push_back(out_data[31:0]);
    end
  end

  initial begin
    int i;
    bit acc;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fflags", 64'(fflags), 64'd0);
    check("rst_out_rd", 64'(out_rd), 64'd0);
    check("rst_out_data", out_data, 64'hFFFF_FFFF_0000_0000);

    // single push, immediate drain
    out_ready = 1'b1;
    push1(32'h3F80_0000, 5'd3, 5'b0);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_data", out_data, 64'hFFFF_FFFF_3F80_0000);
    check("single_rd", 64'(out_rd), 64'd3);
    step();
    check("single_empty", 64'(out_valid), 64'd0);

    // back-pressure
    out_ready = 1'b0;
    dut_log.delete();
    push1(32'h4000_0000, 5'd1, 5'b0);
    push1(32'h4040_0000, 5'd2, 5'b0);
    check("bp_full", 64'(in_ready), 64'd0);
    push1(32'hDEAD_BEEF, 5'd9, 5'b0);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    check("bp_count", 64'(dut_log.size()), 64'd2);
    if (dut_log.size() == 2) begin
      check("bp_first", 64'(dut_log[0]), 64'h4000_0000);
      check("bp_second", 64'(dut_log[1]), 64'h4040_0000);
    end

    // flag accumulation and clear
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    push1(32'h0000_0001, 5'd4, 5'b00001);
    push1(32'h0000_0002, 5'd5, 5'b00100);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    check("flags_acc", 64'(fflags), EN ? 64'b00101 : 64'd0);
    push1(32'h0000_0003, 5'd6, 5'b10000);
    out_ready = 1'b1;
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    out_ready = 1'b0;
    check("flags_clr_pop", 64'(fflags), EN ? 64'b10000 : 64'd0);
    out_ready = 1'b1;
    push1(32'h0000_0004, 5'd7, 5'b11111);
    step();
    out_ready = 1'b0;
    check("flags_all", 64'(fflags), EN ? 64'b11111 : 64'd0);
    check("flags_data", 64'(dut_log[$]), 64'h0000_0004);

    // wrap-around with toggling out_ready
    dut_log.delete();
    i = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (i >= 10 && mq.size() == 0) break;
      in_valid = (i < 10);
      in_s = 32'h1000_0000 + 32'(i);
      in_rd = RD_W'(i);
      out_ready = cyc[0];
      acc = in_valid && in_ready;
      step();
      if (acc) i++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("wrap_pushed", 64'(i), 64'd10);
    check("wrap_written", 64'(dut_log.size()), 64'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < dut_log.size())
        check("wrap_order", 64'(dut_log[k]), 64'(32'h1000_0000 + 32'(k)));
    end

    // reset with entries buffered
    push1(32'h5555_0000, 5'd1, 5'b00010);
    push1(32'h6666_0000, 5'd2, 5'b00010);
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_fflags", 64'(fflags), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_data", out_data, 64'hFFFF_FFFF_0000_0000);
    mq.delete();
    mf = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    dut_log.delete();
    out_ready = 1'b1;
    push1(32'hABCD_0000, 5'd7, 5'b0);
    check("post_rst_data", out_data, 64'hFFFF_FFFF_ABCD_0000);
    check("post_rst_rd", 64'(out_rd), 64'd7);
    step();
    out_ready = 1'b0;
    check("post_rst_count", 64'(dut_log.size()), 64'd1);
    check("post_rst_empty", 64'(out_valid), 64'd0);
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
